// File: rtl/core2axi_ot_pkg.sv
// Constants and order-FIFO entry shared by the core2axi_ot bridge.
// CORE2AXI_OT_ERR_EN adds the request address to each entry for error reporting.
package core2axi_ot_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // Lane index sized for the widest legal bus (128 bits = 4 lanes).
    localparam int OFF_W = 2;

`ifdef CORE2AXI_OT_ERR_EN
    localparam int ENT_ADDR_W = 64;
`endif

    typedef struct packed {
        logic             we;
        logic [OFF_W-1:0] off;
`ifdef CORE2AXI_OT_ERR_EN
        logic [ENT_ADDR_W-1:0] addr;
`endif
    } order_ent_t;

    function automatic int lanes(int data_w);
        return data_w / 32;
    endfunction

endpackage

// File: rtl/core2axi_ot_if.sv
// AXI4 bus between the core2axi_ot bridge (master) and the interconnect (slave).
interface core2axi_ot_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6,
    parameter int USER_W = 6
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_region;
    logic [3:0]          aw_qos;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_region;
    logic [3:0]          ar_qos;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/core2axi_ot_fifo.sv
// Synchronous order FIFO; its occupancy doubles as the bridge's outstanding count.
module core2axi_ot_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  T                 din_i,
    input  logic             pop_i,
    output T                 head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] nxt(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (pop_i)  rd_q <= nxt(rd_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/core2axi_ot.sv
// Core LSU port to AXI4 master bridge with MAX_OT outstanding, in-order responses.
// CORE2AXI_OT_ERR_EN adds data_err_o and err_addr_o (first errored address since reset).
module core2axi_ot
    import core2axi_ot_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID         = 0,
    parameter int MAX_OT         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic [AXI_ADDR_WIDTH-1:0] data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,
`ifdef CORE2AXI_OT_ERR_EN
    output logic                      data_err_o,
    output logic [AXI_ADDR_WIDTH-1:0] err_addr_o,
`endif
    core2axi_ot_if.master             axi
);

    localparam int N     = lanes(AXI_DATA_WIDTH);
    localparam int CNT_W = $clog2(MAX_OT + 1);

    logic [CNT_W-1:0]          cnt;
    logic                      full, empty;
    order_ent_t                push_ent, head;
    logic [OFF_W-1:0]          off;
    logic                      allowed, rd_req, wr_req;
    logic                      ar_hs, aw_hs, w_hs, r_hs, b_hs, gnt, pop;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                      rvalid_q;
    logic [31:0]               rdata_q, rdata_d, r_lane;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;

    assign off = OFF_W'((data_addr_i >> 2) & AXI_ADDR_WIDTH'(N - 1));

    // rst_i gating keeps the bus quiet during reset even if the core holds req.
    assign allowed = data_req_i & ~full & ~rst_i;
    assign rd_req  = allowed & ~data_we_i;
    assign wr_req  = allowed & data_we_i;

    assign axi.ar_valid = rd_req;
    assign axi.aw_valid = wr_req & ~aw_done_q;
    assign axi.w_valid  = wr_req & ~w_done_q;

    assign ar_hs = axi.ar_valid & axi.ar_ready;
    assign aw_hs = axi.aw_valid & axi.aw_ready;
    assign w_hs  = axi.w_valid  & axi.w_ready;
    assign gnt   = ar_hs | (wr_req & (aw_done_q | aw_hs) & (w_done_q | w_hs));

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (gnt) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
        end
    end

    // Fixed single-beat INCR fields on both address channels.
    assign axi.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.aw_addr   = data_addr_i;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = SIZE_4B;
    assign axi.aw_burst  = BURST_INCR;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_user   = '0;
    assign axi.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.ar_addr   = data_addr_i;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = SIZE_4B;
    assign axi.ar_burst  = BURST_INCR;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_user   = '0;
    assign axi.w_last    = 1'b1;
    assign axi.w_user    = '0;

    for (genvar l = 0; l < N; l++) begin : g_lane
        assign w_data[32*l +: 32] = data_wdata_i;
        assign w_strb[4*l +: 4]   = (off == OFF_W'(l)) ? data_be_i : 4'b0;
    end
    assign axi.w_data = w_data;
    assign axi.w_strb = w_strb;

    always_comb begin
        push_ent     = '0;
        push_ent.we  = data_we_i;
        push_ent.off = off;
`ifdef CORE2AXI_OT_ERR_EN
        push_ent.addr = ENT_ADDR_W'(data_addr_i);
`endif
    end

    core2axi_ot_fifo #(
        .T     (order_ent_t),
        .DEPTH (MAX_OT)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .din_i   (push_ent),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (cnt)
    );

    // Only the channel matching the oldest transaction may complete.
    assign axi.r_ready = ~empty & ~head.we & ~rst_i;
    assign axi.b_ready = ~empty &  head.we & ~rst_i;
    assign r_hs = axi.r_valid & axi.r_ready;
    assign b_hs = axi.b_valid & axi.b_ready;
    assign pop  = r_hs | b_hs;

    always_comb begin
        r_lane = '0;
        for (int l = 0; l < N; l++)
            if (head.off == OFF_W'(l)) r_lane = axi.r_data[32*l +: 32];
    end

    assign rdata_d = r_hs ? r_lane : rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= pop;
            rdata_q   <= rdata_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

`ifdef CORE2AXI_OT_ERR_EN
    logic                      err_q, err_d, err_seen_q;
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q;

    assign err_d = (r_hs & (axi.r_resp != RESP_OKAY)) | (b_hs & (axi.b_resp != RESP_OKAY));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= err_d;
            if (err_d && !err_seen_q) begin
                err_seen_q <= 1'b1;
                err_addr_q <= AXI_ADDR_WIDTH'(head.addr);
            end
        end
    end

    assign data_err_o = err_q;
    assign err_addr_o = err_addr_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{axi.r_id, axi.r_last, axi.r_user, axi.r_resp,
                         axi.b_id, axi.b_user, axi.b_resp};

endmodule

// File: tb/tb_core2axi_ot.sv
// Directed bench for core2axi_ot: 32-bit and 64-bit instances driven cycle by cycle.
// Error-reporting checks run only when CORE2AXI_OT_ERR_EN is defined.
module tb_core2axi_ot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        req64, we64, gnt64, rvalid64;
    logic [31:0] addr64, wdata64, rdata64;
    logic [3:0]  be64;
`ifdef CORE2AXI_OT_ERR_EN
    logic        err, err64;
    logic [31:0] err_addr, err_addr64;
`endif

    core2axi_ot_if #(.ADDR_W(32), .DATA_W(32), .ID_W(6), .USER_W(6)) axi ();
    core2axi_ot_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6), .USER_W(6)) axi64 ();

    core2axi_ot #(.AXI_DATA_WIDTH(32), .MAX_OT(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
        .data_wdata_i(wdata), .data_rdata_o(rdata),
`ifdef CORE2AXI_OT_ERR_EN
        .data_err_o(err), .err_addr_o(err_addr),
`endif
        .axi(axi)
    );

    core2axi_ot #(.AXI_DATA_WIDTH(64), .MAX_OT(4)) u_dut64 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req64), .data_gnt_o(gnt64), .data_rvalid_o(rvalid64),
        .data_addr_i(addr64), .data_we_i(we64), .data_be_i(be64),
        .data_wdata_i(wdata64), .data_rdata_o(rdata64),
`ifdef CORE2AXI_OT_ERR_EN
        .data_err_o(err64), .err_addr_o(err_addr64),
`endif
        .axi(axi64)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 0; we = 0; addr = 0; be = 0; wdata = 0;
        req64 = 0; we64 = 0; addr64 = 0; be64 = 0; wdata64 = 0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.r_valid = 0; axi.r_data = '0; axi.r_resp = 0; axi.r_id = '0; axi.r_last = 1; axi.r_user = '0;
        axi.b_valid = 0; axi.b_resp = 0; axi.b_id = '0; axi.b_user = '0;
        axi64.aw_ready = 0; axi64.w_ready = 0; axi64.ar_ready = 0;
        axi64.r_valid = 0; axi64.r_data = '0; axi64.r_resp = 0; axi64.r_id = '0; axi64.r_last = 1; axi64.r_user = '0;
        axi64.b_valid = 0; axi64.b_resp = 0; axi64.b_id = '0; axi64.b_user = '0;

        // reset state
        step(); step(); #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valid_ready", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 0);
        chk("rst_cnt", u_dut.cnt, 0);
        chk("rst_done", {u_dut.aw_done_q, u_dut.w_done_q}, 0);
        rst = 1'b0;

        // 1: single read, R after 3 cycles
        step(); req = 1; we = 0; addr = 32'h1000; axi.ar_ready = 1; #1;
        chk("t1_arvalid", axi.ar_valid, 1);
        chk("t1_gnt", gnt, 1);
        chk("t1_araddr", axi.ar_addr, 32'h1000);
        chk("t1_arfields", {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id, axi.ar_cache},
            {8'd0, 3'b010, 2'b01, 6'd0, 4'd0});
        step(); req = 0; axi.ar_ready = 0; #1;
        chk("t1_cnt1", u_dut.cnt, 1);
        chk("t1_gnt_off", gnt, 0);
        step(); step();
        axi.r_valid = 1; axi.r_data = 32'hDEADBEEF; #1;
        chk("t1_rready", axi.r_ready, 1);
        chk("t1_rvalid_early", rvalid, 0);
        step(); axi.r_valid = 0; #1;
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_cnt0", u_dut.cnt, 0);
        step(); #1;
        chk("t1_rvalid_pulse", rvalid, 0);

        // 2: write, W immediate, AW after 2 cycles
        step(); req = 1; we = 1; addr = 32'h2004; be = 4'hF; wdata = 32'hCAFE0001;
        axi.aw_ready = 0; axi.w_ready = 1; #1;
        chk("t2_c0_aw", axi.aw_valid, 1);
        chk("t2_c0_w", axi.w_valid, 1);
        chk("t2_c0_gnt", gnt, 0);
        chk("t2_wdata", axi.w_data, 32'hCAFE0001);
        chk("t2_wstrb", axi.w_strb, 4'hF);
        chk("t2_wlast", axi.w_last, 1);
        step(); #1;
        chk("t2_c1_w", axi.w_valid, 0);
        chk("t2_c1_aw", axi.aw_valid, 1);
        chk("t2_c1_gnt", gnt, 0);
        step(); axi.aw_ready = 1; #1;
        chk("t2_c2_gnt", gnt, 1);
        chk("t2_c2_w", axi.w_valid, 0);
        chk("t2_awaddr", axi.aw_addr, 32'h2004);
        step(); req = 0; axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 1; #1;
        chk("t2_gnt_once", gnt, 0);
        chk("t2_bready", axi.b_ready, 1);
        chk("t2_cnt1", u_dut.cnt, 1);
        chk("t2_done_clr", {u_dut.aw_done_q, u_dut.w_done_q}, 0);
        step(); axi.b_valid = 0; #1;
        chk("t2_rvalid", rvalid, 1);
        chk("t2_rdata_hold", rdata, 32'hDEADBEEF);
        chk("t2_cnt0", u_dut.cnt, 0);

        // 3: six reads against MAX_OT=4 with R withheld, then drain
        step(); req = 1; we = 0; axi.ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h3000 + 32'(4 * i); #1;
            chk($sformatf("t3_gnt%0d", i), gnt, 1);
            step();
        end
        addr = 32'h3010; #1;
        chk("t3_full_gnt", gnt, 0);
        chk("t3_full_ar", axi.ar_valid, 0);
        chk("t3_full_cnt", u_dut.cnt, 4);
        step(); axi.r_valid = 1; axi.r_data = 32'hA0; #1;
        chk("t3_full_retire_gnt", gnt, 0);
        chk("t3_rready", axi.r_ready, 1);
        step(); axi.r_valid = 0; #1;
        chk("t3_r0_rvalid", rvalid, 1);
        chk("t3_r0_data", rdata, 32'hA0);
        chk("t3_cnt3", u_dut.cnt, 3);
        chk("t3_one_more", gnt, 1);
        step(); addr = 32'h3014; #1;
        chk("t3_refull_gnt", gnt, 0);
        chk("t3_cnt4", u_dut.cnt, 4);
        step(); req = 0; axi.r_valid = 1; axi.r_data = 32'hA1; #1;
        step(); req = 1; axi.r_data = 32'hA2; #1;
        chk("t3_sim_gnt", gnt, 1);
        chk("t3_r1", rdata, 32'hA1);
        chk("t3_cnt_pre", u_dut.cnt, 3);
        step(); req = 0; axi.r_data = 32'hA3; #1;
        chk("t3_sim_cnt", u_dut.cnt, 3);
        chk("t3_r2", rdata, 32'hA2);
        chk("t3_r2_valid", rvalid, 1);
        step(); axi.r_data = 32'hA4; #1;
        chk("t3_r3", rdata, 32'hA3);
        step(); axi.r_data = 32'hA5; #1;
        chk("t3_r4", rdata, 32'hA4);
        step(); axi.r_valid = 0; axi.ar_ready = 0; #1;
        chk("t3_r5", rdata, 32'hA5);
        chk("t3_r5_valid", rvalid, 1);
        chk("t3_drained", u_dut.cnt, 0);

        // 4: write then read, R presented before B
        step(); req = 1; we = 1; addr = 32'h4000; wdata = 32'h44; be = 4'hF;
        axi.aw_ready = 1; axi.w_ready = 1; #1;
        chk("t4_wr_gnt", gnt, 1);
        step(); we = 0; addr = 32'h4008; axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 1; #1;
        chk("t4_rd_gnt", gnt, 1);
        step(); req = 0; axi.ar_ready = 0; axi.r_valid = 1; axi.r_data = 32'h5555AAAA; #1;
        chk("t4_rready_blk", axi.r_ready, 0);
        chk("t4_bready", axi.b_ready, 1);
        step(); #1;
        chk("t4_rready_blk2", axi.r_ready, 0);
        chk("t4_no_rsp", rvalid, 0);
        axi.b_valid = 1; #1;
        chk("t4_rready_at_b", axi.r_ready, 0);
        step(); axi.b_valid = 0; #1;
        chk("t4_wr_rsp", rvalid, 1);
        chk("t4_wr_rdata", rdata, 32'hA5);
        chk("t4_rready_now", axi.r_ready, 1);
        step(); axi.r_valid = 0; #1;
        chk("t4_rd_rsp", rvalid, 1);
        chk("t4_rd_rdata", rdata, 32'h5555AAAA);
        chk("t4_cnt0", u_dut.cnt, 0);

        // 5: 64-bit lane steering
        step(); req64 = 1; we64 = 1; addr64 = 32'h5004; be64 = 4'b0011; wdata64 = 32'h12345678;
        axi64.aw_ready = 1; axi64.w_ready = 1; #1;
        chk("t5_wstrb_hi", axi64.w_strb, 8'h30);
        chk("t5_wdata", axi64.w_data, 64'h12345678_12345678);
        chk("t5_gnt", gnt64, 1);
        step(); addr64 = 32'h5000; be64 = 4'hF; #1;
        chk("t5_wstrb_lo", axi64.w_strb, 8'h0F);
        chk("t5_gnt2", gnt64, 1);
        step(); we64 = 0; addr64 = 32'h5004; axi64.aw_ready = 0; axi64.w_ready = 0; axi64.ar_ready = 1; #1;
        chk("t5_rgnt", gnt64, 1);
        step(); addr64 = 32'h5000; #1;
        chk("t5_rgnt2", gnt64, 1);
        step(); req64 = 0; axi64.ar_ready = 0; axi64.b_valid = 1; #1;
        step();
        step(); axi64.b_valid = 0; axi64.r_valid = 1; axi64.r_data = 64'h11112222_33334444; #1;
        step(); #1;
        chk("t5_rdata_hi", rdata64, 32'h11112222);
        step(); axi64.r_valid = 0; #1;
        chk("t5_rdata_lo", rdata64, 32'h33334444);
        chk("t5_cnt0", u_dut64.cnt, 0);

`ifdef CORE2AXI_OT_ERR_EN
        // 6a: SLVERR reporting, first address sticks
        step(); #1;
        chk("t6_erraddr_init", err_addr, 0);
        req = 1; we = 0; addr = 32'h2000; axi.ar_ready = 1; #1;
        chk("t6_gnt0", gnt, 1);
        step(); addr = 32'h2100; #1;
        chk("t6_gnt1", gnt, 1);
        step(); req = 0; axi.ar_ready = 0; axi.r_valid = 1; axi.r_resp = 2'b10; axi.r_data = '0; #1;
        step(); #1;
        chk("t6_err", err, 1);
        chk("t6_err_rvalid", rvalid, 1);
        chk("t6_erraddr", err_addr, 32'h2000);
        step(); axi.r_valid = 0; axi.r_resp = 2'b00; #1;
        chk("t6_err2", err, 1);
        chk("t6_erraddr_first", err_addr, 32'h2000);
        step(); #1;
        chk("t6_err_clr", err, 0);
`endif

        // 6b: reset with 3 reads outstanding
        step(); req = 1; we = 0; axi.ar_ready = 1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h6000 + 32'(4 * i); #1;
            step();
        end
        req = 0; axi.ar_ready = 0; #1;
        chk("t6_cnt3", u_dut.cnt, 3);
        rst = 1'b1;
        step(); #1;
        chk("t6_rst_cnt", u_dut.cnt, 0);
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_valid_ready", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 0);
`ifdef CORE2AXI_OT_ERR_EN
        chk("t6_rst_err", {err, err_addr}, 0);
`endif
        rst = 1'b0;
        step(); req = 1; addr = 32'h7000; axi.ar_ready = 1; #1;
        chk("t6_post_gnt", gnt, 1);
        step(); req = 0; axi.ar_ready = 0; axi.r_valid = 1; axi.r_data = 32'h600D600D; #1;
        chk("t6_post_cnt", u_dut.cnt, 1);
        chk("t6_post_rready", axi.r_ready, 1);
        step(); axi.r_valid = 0; #1;
        chk("t6_post_rdata", rdata, 32'h600D600D);
        chk("t6_post_cnt0", u_dut.cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core2axi_ot.md
Name: core2axi_ot

Overview:
Core data-port to AXI4 master bridge. Successor to the single-transaction core-to-AXI bridge, with these additions:
- multiple outstanding transactions
- parametrised AXI data width with byte-lane steering
- strict in-order response return to the core across the R and B channels

It sits between the core LSU port and the AXI interconnect master slot.

Parameters:
AXI_ADDR_WIDTH, 32, address width; core address has the same width.
AXI_DATA_WIDTH, 32, AXI data width; legal values 32, 64, 128.
AXI_ID_WIDTH, 6, ID width.
AXI_USER_WIDTH, 6, user width.
AXI_ID, 0, constant ID driven on AW and AR.
MAX_OT, 4, maximum outstanding transactions, 1..16; also the order-FIFO depth.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, synchronous, active-high.
- data_req_i in 1: core request.
- data_gnt_o out 1: request accepted.
- data_rvalid_o out 1: response valid.
- data_addr_i in AXI_ADDR_WIDTH: byte address.
- data_we_i in 1: 1 = write.
- data_be_i in 4: byte enables.
- data_wdata_i in 32: write data.
- data_rdata_o out 32: read data.
- aw_*, w_*, b_*, ar_*, r_*: full AXI4 master port, widths from the parameters. Data width is AXI_DATA_WIDTH; strobe width is AXI_DATA_WIDTH/8.

Behaviour:
Reset:
- All valid and ready outputs are 0.
- data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 0.
- Outstanding count = 0; order FIFO empty; aw_done = 0, w_done = 0.

Core protocol:
- The core holds req, addr, we, be and wdata stable until gnt.
- Responses are returned in request order.

Issue:
- Issue is allowed when data_req_i = 1 and count < MAX_OT.
- When count == MAX_OT, all valids are 0 and gnt is 0.

Read issue:
- ar_valid = req & allowed.
- gnt is asserted in the cycle of the ar_valid & ar_ready handshake.

Write issue:
- aw_valid = req & we & allowed & !aw_done.
- w_valid = req & we & allowed & !w_done.
- AW and W may handshake in different cycles; the done flags record completion.
- gnt is asserted in the cycle the last remaining channel handshakes.
- If both handshake in the same cycle, gnt is asserted in that cycle.
- Both done flags clear on gnt.

Fixed AXI fields:
- len = 0, size = 3'b010, burst = INCR (2'b01), last = 1.
- lock, cache, prot, region, qos and user are all 0.
- AW and AR carry id = AXI_ID and addr = data_addr_i unchanged.

Lane steering (N = AXI_DATA_WIDTH/32, off = addr[log2(AXI_DATA_WIDTH/8)-1:2]):
- w_data = data_wdata_i replicated N times.
- w_strb = data_be_i << (4*off).
- For N = 1, off is 0.

Order FIFO:
- On gnt, push {we, off}.
- Order-FIFO occupancy equals the outstanding count.

Response gating:
- r_ready = head valid & head is a read.
- b_ready = head valid & head is a write.
- A response on the channel not at the head stalls. No buffering.

Retire:
- On the R or B handshake, pop the FIFO.
- The next cycle: data_rvalid_o = 1.
- For a read, data_rdata_o = r_data[32*off +: 32]; for a write, data_rdata_o holds its previous value.
- Sustained throughput is one retire per cycle.

Counter:
- Increments on gnt, decrements on retire.
- Gnt and retire in the same cycle leave it unchanged.
- Issue is allowed at count == MAX_OT-1 even if a retire occurs in the same cycle.

Reset mid-operation:
- All state is cleared and in-flight transactions are dropped.
- The interconnect and slave share rst_i.

Optional Feature:
Macro: CORE2AXI_OT_ERR_EN.
- Defined:
  - Adds port data_err_o (out, 1), valid with data_rvalid_o.
  - data_err_o = 1 when r_resp or b_resp != OKAY (2'b00).
  - Adds port err_addr_o (out, AXI_ADDR_WIDTH), which holds the address of the first errored transaction since reset.
  - The address is stored in the FIFO entry.
- Undefined:
  - Neither port exists.
  - resp is ignored; no address storage.

Decomposition:
- Package core2axi_ot_pkg:
  - constants RESP_OKAY, BURST_INCR, SIZE_4B;
  - the order-entry struct type (we, off, plus addr under the macro).
- Sub-module core2axi_ot_fifo:
  - synchronous FIFO parametrised by entry type and DEPTH = MAX_OT;
  - ports push, pop, head, full, empty, count.

Test Plan:
1. Single read, 32-bit data width: addr 0x1000, slave returns 0xDEADBEEF after 3 cycles -> gnt in the AR handshake cycle; rvalid 1 cycle after the R handshake; rdata = 0xDEADBEEF.
2. Write with aw_ready delayed 2 cycles, w_ready immediate -> W handshakes at cycle 0, AW at cycle 2; a single gnt at cycle 2; w_valid does not reassert.
3. MAX_OT = 4, 6 back-to-back reads, slave withholds R -> 4 gnts, then gnt = 0 with ar_valid = 0; after one R, exactly one further gnt.
4. Write then read issued; slave presents R before B -> r_ready stays 0 until the B handshake; core sees the write response then the read response, in order.
5. AXI_DATA_WIDTH = 64, write to 0x...04 with be = 4'b0011 -> w_strb = 8'h30; read from 0x...04 with r_data = 64'h11112222_33334444 -> rdata = 0x11112222.
6. With CORE2AXI_OT_ERR_EN, read to 0x2000 answered with SLVERR (2'b10) -> data_err_o = 1 with rvalid, err_addr_o = 0x2000. Separately, rst_i asserted with 3 outstanding -> next cycle count 0 and all outputs at their reset values.
